// File: rtl/sp_ram_pkg.sv
// Shared encodings for the single-port RAM FIFO controller.
// State codes and {cs,we,oe} RAM command words.
package sp_ram_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RD_CAP = 1'b1
  } state_t;

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_WR  = 3'b110;
  localparam logic [2:0] CMD_RD  = 3'b101;

endpackage

// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM with a shared bidirectional data bus.
// Read data appears the cycle after the read is sampled.
module single_port_sync_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_q;

  // write stores the bus; read latches the addressed word
  always_ff @(posedge clk) begin
    if (cs && we) begin
      r_mem[addr] <= data;
    end else if (cs && oe) begin
      r_q <= r_mem[addr];
    end
  end

  assign data = (cs && !we && oe) ? r_q : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller time-sharing one synchronous RAM port.
// Reads fill a one-entry output register; reads win over pushes.
module sp_ram_fifo_ctrl
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH:0]   r_level;
  logic [ADDR_WIDTH:0]   w_level_nxt;
  logic                  r_full;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  w_rd_issue;
  logic                  w_wr_issue;
  logic                  w_in_ready;
  logic [2:0]            w_cmd;

  // arbitrate the RAM port: read issue first, else accept a push
  always_comb begin
    w_state_nxt = r_state;
    w_cmd       = CMD_NOP;
    w_addr      = r_addr;
    w_rd_issue  = 1'b0;
    w_wr_issue  = 1'b0;
    w_in_ready  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_level != '0 &&
              (!r_out_valid || out_ready)) begin
            w_rd_issue  = 1'b1;
            w_cmd       = CMD_RD;
            w_addr      = r_rd_ptr;
            w_state_nxt = ST_RD_CAP;
          end else begin
            w_in_ready = !r_full;
            if (in_valid && !r_full) begin
              w_wr_issue = 1'b1;
              w_cmd      = CMD_WR;
              w_addr     = r_wr_ptr;
            end
          end
        end
        ST_RD_CAP: begin
          w_cmd       = CMD_RD;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // occupancy after this cycle's single RAM operation
  always_comb begin
    w_level_nxt = r_level;
    unique case (1'b1)
      w_wr_issue: w_level_nxt = r_level + 1'b1;
      w_rd_issue: w_level_nxt = r_level - 1'b1;
      default:    w_level_nxt = r_level;
    endcase
  end

  // state, pointers, address hold and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_addr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      if (w_wr_issue) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // output register: capture beats a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (r_state == ST_RD_CAP) begin
      r_out_valid <= 1'b1;
      r_out_data  <= ram_data;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign level     = r_level;
  assign full      = r_full;
  assign empty     = (r_level == '0) && !r_out_valid;
  assign ram_cs    = w_cmd[2];
  assign ram_we    = w_cmd[1];
  assign ram_oe    = w_cmd[0];
  assign ram_addr  = w_addr;
  assign ram_data  = w_wr_issue ? in_data
                                : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Bench for sp_ram_fifo_ctrl paired with single_port_sync_ram.
// Cycle table plus directed fill/drain, stream and reset cases.
module tb_sp_ram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic [3:0]  ram_addr;
  wire  [15:0] ram_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sp_ram_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .full(full), .empty(empty),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  single_port_sync_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_ram (
    .clk(clk), .cs(ram_cs), .we(ram_we), .oe(ram_oe),
    .addr(ram_addr), .data(ram_data)
  );

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [15:0] din;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_od;
    logic [4:0]  e_lvl;
    logic        e_full;
    logic        e_empty;
    logic        e_cs;
    logic        e_we;
  } vec_t;

  vec_t tv [17];

  function automatic vec_t mk(
    input logic r, input logic iv, input logic [15:0] d,
    input logic o, input logic ir, input logic ov,
    input logic [15:0] od, input logic [4:0] lv,
    input logic f, input logic e, input logic cs, input logic we
  );
    vec_t v;
    v = '{r, iv, d, o, ir, ov, od, lv, f, e, cs, we};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      done = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("push_accept", 32'(done), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    //  rst iv din      or | ir ov od      lvl f e cs we
    tv[0]  = mk(1, 1, 16'hA5A5, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0);
    tv[1]  = mk(0, 1, 16'hA5A5, 0, 1, 0, 16'h0000, 0, 0, 1, 1, 1);
    tv[2]  = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0);
    tv[3]  = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 0);
    tv[4]  = mk(0, 0, 16'h0000, 0, 1, 1, 16'hA5A5, 0, 0, 0, 0, 0);
    tv[5]  = mk(0, 0, 16'h0000, 1, 1, 1, 16'hA5A5, 0, 0, 0, 0, 0);
    tv[6]  = mk(0, 0, 16'h0000, 1, 1, 0, 16'hA5A5, 0, 0, 1, 0, 0);
    tv[7]  = mk(0, 1, 16'h1111, 0, 1, 0, 16'hA5A5, 0, 0, 1, 1, 1);
    tv[8]  = mk(0, 1, 16'h2222, 0, 0, 0, 16'hA5A5, 1, 0, 0, 1, 0);
    tv[9]  = mk(0, 1, 16'h2222, 0, 0, 0, 16'hA5A5, 0, 0, 1, 1, 0);
    tv[10] = mk(0, 1, 16'h2222, 0, 1, 1, 16'h1111, 0, 0, 0, 1, 1);
    tv[11] = mk(0, 0, 16'h0000, 0, 1, 1, 16'h1111, 1, 0, 0, 0, 0);
    tv[12] = mk(0, 0, 16'h0000, 1, 0, 1, 16'h1111, 1, 0, 0, 1, 0);
    tv[13] = mk(0, 0, 16'h0000, 0, 0, 0, 16'h1111, 0, 0, 1, 1, 0);
    tv[14] = mk(0, 0, 16'h0000, 0, 1, 1, 16'h2222, 0, 0, 0, 0, 0);
    tv[15] = mk(1, 0, 16'h0000, 0, 0, 1, 16'h2222, 0, 0, 0, 0, 0);
    tv[16] = mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);

    // table: one row per cycle, outputs checked before the edge
    for (int i = 0; i < 17; i++) begin
      rst       = tv[i].rst;
      in_valid  = tv[i].iv;
      in_data   = tv[i].din;
      out_ready = tv[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tv[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tv[i].e_ov));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tv[i].e_od));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tv[i].e_lvl));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tv[i].e_full));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tv[i].e_empty));
      chk($sformatf("v%0d_ram_cs", i), 32'(ram_cs), 32'(tv[i].e_cs));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(tv[i].e_we));
      @(negedge clk);
    end

    // fill: 17 words, one in output register, 16 in RAM
    begin
      int exp_w;
      int cyc;
      int last;
      logic [3:0] rd_addr;
      do_reset();
      for (int i = 0; i < 17; i++) push(16'(i));
      in_valid = 1'b1;
      in_data  = 16'h0011;
      for (int k = 0; k < 3; k++) begin
        #1;
        chk("full_level", 32'(level), 32'd16);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_no_ram", 32'(ram_cs), 32'd0);
        @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      exp_w = 0; cyc = 0; last = 0; rd_addr = 4'hF;
      while (exp_w < 17 && cyc < 100) begin
        #1;
        if (ram_cs && ram_oe) rd_addr = ram_addr;
        if (out_valid) begin
          chk("drain_data", 32'(out_data), 32'(exp_w));
          if (exp_w > 0)
            chk("drain_interval", 32'(cyc - last), 32'd2);
          last = cyc;
          exp_w++;
        end
        @(negedge clk);
        cyc++;
      end
      chk("drain_count", 32'(exp_w), 32'd17);
      #1;
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_level", 32'(level), 32'd0);
      chk("drain_full", 32'(full), 32'd0);
      chk("drain_last_rd_addr", 32'(rd_addr), 32'd0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      #1;
      chk("wrap_wr_we", 32'(ram_we), 32'd1);
      chk("wrap_wr_addr", 32'(ram_addr), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
    end

    // streaming: push every cycle, pop every cycle
    begin
      logic [15:0] q [$];
      int buserr;
      int pops;
      logic [15:0] e;
      do_reset();
      buserr = 0; pops = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 300; c++) begin
        if (c >= 200) in_valid = 1'b0;
        in_data = 16'(c);
        #1;
        if (ram_we && $isunknown(ram_data)) buserr++;
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("stream_extra_pop", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("stream_data", 32'(out_data), 32'(e));
            pops++;
          end
        end
        if (in_valid && in_ready) q.push_back(in_data);
        @(negedge clk);
      end
      chk("stream_left", 32'(q.size()), 32'd0);
      chk("stream_bus_x", 32'(buserr), 32'd0);
      chk("stream_some_pops", 32'(pops >= 50), 32'd1);
      #1;
      chk("stream_empty", 32'(empty), 32'd1);
      @(negedge clk);
    end

    // reset while a read capture is in flight
    begin
      bit got;
      do_reset();
      for (int i = 0; i < 7; i++) push(16'h0100 + 16'(i));
      out_ready = 1'b1;
      #1;
      chk("rc_pre_level", 32'(level), 32'd6);
      chk("rc_issue", 32'({ram_cs, ram_we, ram_oe}), 32'b101);
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("rc_cap_level", 32'(level), 32'd5);
      chk("rc_cap_cmd", 32'({ram_cs, ram_we, ram_oe}), 32'b101);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rc_out_valid", 32'(out_valid), 32'd0);
      chk("rc_level", 32'(level), 32'd0);
      chk("rc_ram_cs", 32'(ram_cs), 32'd0);
      chk("rc_empty", 32'(empty), 32'd1);
      @(negedge clk);
      push(16'h1234);
      out_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        #1;
        if (out_valid) begin
          chk("rc_repush_data", 32'(out_data), 32'h1234);
          got = 1'b1;
        end
        @(negedge clk);
      end
      chk("rc_repush_seen", 32'(got), 32'd1);
      out_ready = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
